// File: rtl/riscv_trap_ctrl.sv
// riscv_trap_ctrl: machine-mode trap sequencer plus CLINT mtime/mtimecmp.
// Detects ecall/ebreak/mret/timer interrupt in IDLE, stalls the pipeline,
// walks mepc/mcause/mstatus through the single CSR write port, then
// redirects the PC. Idle cycles forward instruction CSR writes.
module riscv_trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    input  logic [XLEN-1:0] inst_pc,
    input  logic            is_ecall,
    input  logic            is_ebreak,
    input  logic            is_mret,
    input  logic            inst_csr_we,
    input  logic [11:0]     inst_csr_waddr,
    input  logic [XLEN-1:0] inst_csr_wdata,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    input  logic [XLEN-1:0] csr_mstatus,
    input  logic [XLEN-1:0] csr_mie,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            halt,
    input  logic            tmr_we,
    input  logic [3:0]      tmr_addr,
    input  logic [XLEN-1:0] tmr_wdata,
    output logic [XLEN-1:0] tmr_rdata,
    output logic            timer_irq
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SAVE_EPC    = 3'd1,
        SAVE_CAUSE  = 3'd2,
        SAVE_STATUS = 3'd3,
        MRET_STATUS = 3'd4,
        REDIRECT    = 3'd5,
        HALT        = 3'd6
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] mstatus_saved;
    logic [63:0]     mtime;
    logic [63:0]     mtimecmp;
    logic            irq_take;
    logic            event_taken;
    logic            unused_mie;

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
    function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r        = ms;
        r[7]     = ms[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Trap return: MIE <= MPIE, MPIE <= 1, MPP stays M (only mode here).
    function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r        = ms;
        r[3]     = ms[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    assign unused_mie  = ^{csr_mie[XLEN-1:8], csr_mie[6:0]};
    assign timer_irq   = (mtime >= mtimecmp);
    assign irq_take    = inst_valid & timer_irq & csr_mstatus[3] & csr_mie[7];
    assign event_taken = inst_valid & (irq_take | is_ecall | is_ebreak | is_mret);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; events only considered in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (irq_take) begin
                    state_next = SAVE_EPC;
                end else if (inst_valid & is_ebreak) begin
                    state_next = HALT;
                end else if (inst_valid & is_ecall) begin
                    state_next = SAVE_EPC;
                end else if (inst_valid & is_mret) begin
                    state_next = MRET_STATUS;
                end else begin
                    state_next = IDLE;
                end
            end
            SAVE_EPC:    state_next = SAVE_CAUSE;
            SAVE_CAUSE:  state_next = SAVE_STATUS;
            SAVE_STATUS: state_next = REDIRECT;
            MRET_STATUS: state_next = REDIRECT;
            REDIRECT:    state_next = IDLE;
            HALT:        state_next = HALT;
            default:     state_next = IDLE;
        endcase
    end

    // Capture trap context in the detection cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc           <= '0;
            cause         <= '0;
            target        <= '0;
            mstatus_saved <= '0;
        end else if ((state == IDLE) && event_taken) begin
            epc           <= inst_pc;
            mstatus_saved <= csr_mstatus;
            if (irq_take) begin
                cause  <= {1'b1, {(XLEN-4){1'b0}}, 3'b111};
                target <= csr_mtvec & ~XLEN'(3);
            end else if (is_ebreak) begin
                cause  <= XLEN'(3);
                target <= csr_mtvec & ~XLEN'(3);
            end else if (is_ecall) begin
                cause  <= XLEN'(11);
                target <= csr_mtvec & ~XLEN'(3);
            end else begin
                cause  <= cause;
                target <= csr_mepc;
            end
        end else begin
            epc           <= epc;
            cause         <= cause;
            target        <= target;
            mstatus_saved <= mstatus_saved;
        end
    end

    // Output decode: CSR port arbitration, stall, redirect, halt.
    always_comb begin
        csr_we         = 1'b0;
        csr_waddr      = 12'h000;
        csr_wdata      = '0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        case (state)
            IDLE: begin
                if (!event_taken && !rst) begin
                    csr_we    = inst_csr_we;
                    csr_waddr = inst_csr_waddr;
                    csr_wdata = inst_csr_wdata;
                end else begin
                    csr_we    = 1'b0;
                end
                stall = event_taken & ~rst;
            end
            SAVE_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h341;
                csr_wdata = epc;
                stall     = 1'b1;
            end
            SAVE_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h342;
                csr_wdata = cause;
                stall     = 1'b1;
            end
            SAVE_STATUS: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h300;
                csr_wdata = trap_status(mstatus_saved);
                stall     = 1'b1;
            end
            MRET_STATUS: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h300;
                csr_wdata = mret_status(mstatus_saved);
                stall     = 1'b1;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = target;
            end
            HALT: begin
                stall = 1'b1;
                halt  = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // mtime free-runs; a half-write replaces that half instead of counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime    <= 64'd0;
            mtimecmp <= {64{1'b1}};
        end else begin
            if (tmr_we && (tmr_addr == 4'h8)) begin
                mtime <= {mtime[63:32], tmr_wdata[31:0]};
            end else if (tmr_we && (tmr_addr == 4'hC)) begin
                mtime <= {tmr_wdata[31:0], mtime[31:0]};
            end else begin
                mtime <= mtime + 64'd1;
            end
            if (tmr_we && (tmr_addr == 4'h0)) begin
                mtimecmp <= {mtimecmp[63:32], tmr_wdata[31:0]};
            end else if (tmr_we && (tmr_addr == 4'h4)) begin
                mtimecmp <= {tmr_wdata[31:0], mtimecmp[31:0]};
            end else begin
                mtimecmp <= mtimecmp;
            end
        end
    end

    // Combinational timer register read.
    always_comb begin
        tmr_rdata = '0;
        case (tmr_addr)
            4'h0:    tmr_rdata = mtimecmp[31:0];
            4'h4:    tmr_rdata = mtimecmp[63:32];
            4'h8:    tmr_rdata = mtime[31:0];
            4'hC:    tmr_rdata = mtime[63:32];
            default: tmr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Self-checking bench for riscv_trap_ctrl: directed scenarios plus a
// randomized run checked against a cycle-level action-script model.
module tb_riscv_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid, is_ecall, is_ebreak, is_mret;
    logic [31:0] inst_pc;
    logic        inst_csr_we;
    logic [11:0] inst_csr_waddr;
    logic [31:0] inst_csr_wdata;
    logic [31:0] csr_mtvec, csr_mepc, csr_mstatus, csr_mie;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        stall, redirect_valid, halt, timer_irq;
    logic [31:0] redirect_pc;
    logic        tmr_we;
    logic [3:0]  tmr_addr;
    logic [31:0] tmr_wdata, tmr_rdata;

    riscv_trap_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_pc(inst_pc),
        .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret),
        .inst_csr_we(inst_csr_we), .inst_csr_waddr(inst_csr_waddr),
        .inst_csr_wdata(inst_csr_wdata), .csr_mtvec(csr_mtvec),
        .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus), .csr_mie(csr_mie),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .tmr_we(tmr_we),
        .tmr_addr(tmr_addr), .tmr_wdata(tmr_wdata), .tmr_rdata(tmr_rdata),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // One expected cycle of port activity.
    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
    } act_t;

    act_t        q[$];
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    bit          m_halt;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic act_t mk(input logic we, input logic [11:0] a, input logic [31:0] d,
                                input logic st, input logic rv, input logic [31:0] pc);
        act_t x;
        x.we = we; x.addr = a; x.data = d; x.stall = st; x.rv = rv; x.rpc = pc;
        return x;
    endfunction

    task automatic clear_inputs();
        inst_valid = 1'b0; is_ecall = 1'b0; is_ebreak = 1'b0; is_mret = 1'b0;
        inst_pc = 32'h0; inst_csr_we = 1'b0; inst_csr_waddr = 12'h0;
        inst_csr_wdata = 32'h0; csr_mtvec = 32'h0; csr_mepc = 32'h0;
        csr_mstatus = 32'h0; csr_mie = 32'h0; tmr_we = 1'b0;
        tmr_addr = 4'h8; tmr_wdata = 32'h0;
    endtask

    // Compare one cycle against the model, advance the model, move to next cycle.
    task automatic step();
        act_t        e;
        logic        irq;
        logic [31:0] rd;
        logic [31:0] ms;
        bit          go_halt;
        #2;
        go_halt = 0;
        irq = (m_time >= m_cmp);
        ms  = csr_mstatus;
        e   = mk(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        if (m_halt) begin
            e.stall = 1'b1;
        end else if (q.size() > 0) begin
            e = q.pop_front();
        end else if (inst_valid && (irq && ms[3] && csr_mie[7] || is_ecall)) begin
            e.stall = 1'b1;
            q.push_back(mk(1'b1, 12'h341, inst_pc, 1'b1, 1'b0, 32'h0));
            q.push_back(mk(1'b1, 12'h342, (irq && ms[3] && csr_mie[7]) ? 32'h8000_0007 : 32'd11,
                           1'b1, 1'b0, 32'h0));
            q.push_back(mk(1'b1, 12'h300,
                           (ms & ~32'h1888) | (((ms >> 3) & 32'd1) << 7) | 32'h1800,
                           1'b1, 1'b0, 32'h0));
            q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b0, 1'b1, csr_mtvec & 32'hFFFF_FFFC));
        end else if (inst_valid && is_ebreak) begin
            e.stall = 1'b1;
            go_halt = 1;
        end else if (inst_valid && is_mret) begin
            e.stall = 1'b1;
            q.push_back(mk(1'b1, 12'h300,
                           (ms & ~32'h1888) | (((ms >> 7) & 32'd1) << 3) | 32'h1880,
                           1'b1, 1'b0, 32'h0));
            q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b0, 1'b1, csr_mepc));
        end else begin
            e.we = inst_csr_we; e.addr = inst_csr_waddr; e.data = inst_csr_wdata;
        end
        case (tmr_addr)
            4'h0:    rd = m_cmp[31:0];
            4'h4:    rd = m_cmp[63:32];
            4'h8:    rd = m_time[31:0];
            4'hC:    rd = m_time[63:32];
            default: rd = 32'h0;
        endcase
        check("csr_we", csr_we, e.we);
        if (e.we) begin
            check("csr_waddr", csr_waddr, e.addr);
            check("csr_wdata", csr_wdata, e.data);
        end
        check("stall", stall, e.stall);
        check("redirect_valid", redirect_valid, e.rv);
        check("redirect_pc", redirect_pc, e.rpc);
        check("halt", halt, m_halt);
        check("timer_irq", timer_irq, irq);
        check("tmr_rdata", tmr_rdata, rd);
        if (go_halt) m_halt = 1;
        if (tmr_we && tmr_addr == 4'h8)      m_time = {m_time[63:32], tmr_wdata};
        else if (tmr_we && tmr_addr == 4'hC) m_time = {tmr_wdata, m_time[31:0]};
        else                                  m_time = m_time + 64'd1;
        if (tmr_we && tmr_addr == 4'h0) m_cmp[31:0]  = tmr_wdata;
        if (tmr_we && tmr_addr == 4'h4) m_cmp[63:32] = tmr_wdata;
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously, check the reset outputs, release after an edge.
    task automatic apply_reset();
        inst_csr_we = 1'b1; inst_csr_waddr = 12'h305; inst_csr_wdata = 32'h55;
        rst = 1'b1;
        #1;
        check("rst_csr_we", csr_we, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_redirect_valid", redirect_valid, 1'b0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_halt", halt, 1'b0);
        check("rst_timer_irq", timer_irq, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_halt = 0;
        m_time = 64'd0;
        m_cmp  = {64{1'b1}};
        clear_inputs();
    endtask

    task automatic rand_inputs();
        int op;
        logic [3:0] amap [7];
        amap = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h2, 4'h6, 4'hE};
        op = $urandom_range(0, 9);
        inst_valid     = 1'($urandom_range(0, 1));
        is_ecall       = (op == 0);
        is_mret        = (op == 1);
        is_ebreak      = 1'b0;
        inst_pc        = $urandom;
        inst_csr_we    = 1'($urandom_range(0, 1));
        inst_csr_waddr = 12'($urandom);
        inst_csr_wdata = $urandom;
        csr_mtvec      = $urandom;
        csr_mepc       = $urandom;
        csr_mstatus    = $urandom;
        csr_mie        = $urandom;
        tmr_we         = ($urandom_range(0, 7) == 0);
        tmr_addr       = amap[$urandom_range(0, 6)];
        if (tmr_addr == 4'h4 || tmr_addr == 4'hC) tmr_wdata = 32'h0;
        else tmr_wdata = m_time[31:0] + 32'($urandom_range(0, 40));
    endtask

    initial begin : main
        bit found;
        clear_inputs();
        m_time = 64'd0; m_cmp = {64{1'b1}}; m_halt = 0;
        @(posedge clk);
        #1;
        apply_reset();

        // Directed ecall trap entry.
        inst_valid = 1'b1; is_ecall = 1'b1; inst_pc = 32'h8000_0010;
        csr_mtvec = 32'h8000_0101; csr_mstatus = 32'h8;
        #1; check("ecall_stall_D", stall, 1'b1);
        step();
        clear_inputs();
        #1; check("ecall_mepc", csr_wdata, 32'h8000_0010);
        step();
        #1; check("ecall_mcause", csr_wdata, 32'd11);
        step();
        #1; check("ecall_mstatus", csr_wdata, 32'h1880);
        step();
        #1; check("ecall_redirect", redirect_pc, 32'h8000_0100);
        step();

        // Directed mret.
        inst_valid = 1'b1; is_mret = 1'b1; csr_mepc = 32'h8000_0014; csr_mstatus = 32'h1880;
        step();
        clear_inputs();
        #1; check("mret_mstatus", csr_wdata, 32'h1888);
        step();
        #1; check("mret_redirect", redirect_pc, 32'h8000_0014);
        step();

        // Idle CSRRW forwarding.
        inst_csr_we = 1'b1; inst_csr_waddr = 12'h305; inst_csr_wdata = 32'h1234;
        #1;
        check("idle_fwd_we", csr_we, 1'b1);
        check("idle_fwd_addr", csr_waddr, 12'h305);
        check("idle_fwd_data", csr_wdata, 32'h1234);
        step();

        // CSRRW during SAVE_CAUSE, then reset mid-sequence.
        clear_inputs();
        inst_valid = 1'b1; is_ecall = 1'b1; inst_pc = 32'h8000_0020;
        step();
        clear_inputs();
        step();
        inst_csr_we = 1'b1; inst_csr_waddr = 12'h305; inst_csr_wdata = 32'h1234;
        #1;
        check("busy_no_fwd_addr", csr_waddr, 12'h342);
        check("busy_no_fwd_data", csr_wdata, 32'd11);
        apply_reset();
        check("post_rst_stall", stall, 1'b0);

        // Timer interrupt preempts a held CSRRW when mtime reaches 5.
        tmr_we = 1'b1; tmr_addr = 4'h4; tmr_wdata = 32'h0;
        step();
        tmr_addr = 4'h0; tmr_wdata = 32'd5;
        step();
        tmr_we = 1'b0; tmr_addr = 4'h8;
        inst_valid = 1'b1; inst_pc = 32'h8000_0040; csr_mstatus = 32'h8; csr_mie = 32'h80;
        csr_mtvec = 32'h8000_0200;
        inst_csr_we = 1'b1; inst_csr_waddr = 12'h305; inst_csr_wdata = 32'h1234;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (timer_irq) begin
                found = 1;
                break;
            end
            step();
        end
        check("irq_seen", 1'(found), 1'b1);
        check("irq_mtime", tmr_rdata, 32'd5);
        check("irq_csr_drop", csr_we, 1'b0);
        step();
        inst_valid = 1'b0; inst_csr_we = 1'b0;
        #1; check("irq_mepc", csr_wdata, 32'h8000_0040);
        step();
        #1; check("irq_mcause", csr_wdata, 32'h8000_0007);
        step();
        step();
        csr_mie = 32'h0;
        step();

        // Randomized run against the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        // mtime wrap.
        clear_inputs();
        tmr_we = 1'b1; tmr_addr = 4'hC; tmr_wdata = 32'hFFFF_FFFF;
        step();
        tmr_addr = 4'h8; tmr_wdata = 32'hFFFF_FFFE;
        step();
        tmr_we = 1'b0;
        #1; check("wrap_lo_fe", tmr_rdata, 32'hFFFF_FFFE);
        step();
        #1; check("wrap_lo_ff", tmr_rdata, 32'hFFFF_FFFF);
        step();
        #1; check("wrap_lo_0", tmr_rdata, 32'h0);
        tmr_addr = 4'hC;
        #1; check("wrap_hi_0", tmr_rdata, 32'h0);
        step();

        // ebreak halts until reset.
        clear_inputs();
        inst_valid = 1'b1; is_ebreak = 1'b1;
        step();
        inst_csr_we = 1'b1; inst_csr_waddr = 12'h305;
        #1;
        check("ebreak_halt", halt, 1'b1);
        check("ebreak_stall", stall, 1'b1);
        check("ebreak_no_we", csr_we, 1'b0);
        for (int i = 0; i < 100; i++) begin
            rand_inputs();
            step();
        end
        apply_reset();
        #1; check("halt_cleared", halt, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_trap_ctrl.md
# riscv_trap_ctrl

Machine-mode trap sequencer and timer for the NPC core, sitting between the execute stage and `riscv_csr_regfile`. It detects ecall, ebreak, mret and machine-timer interrupts, then stalls the pipeline. Over successive cycles it writes mepc, mcause and mstatus through the single CSR write port and finally redirects the PC. In idle cycles it passes instruction CSR writes (CSRRW/S/C) through to the same port. It also contains the CLINT mtime/mtimecmp pair.

## Interface
- `XLEN`, 32, data/address width (equals `DATA_WIDTH`)
- `clk` input 1: sole clock
- `rst` input 1: asynchronous, active-high reset
- `inst_valid` input 1: execute-stage instruction valid
- `inst_pc` input XLEN: PC of that instruction
- `is_ecall`, `is_ebreak`, `is_mret` input 1 each: decoded, mutually exclusive, qualified by `inst_valid`
- `inst_csr_we` input 1, `inst_csr_waddr` input 12, `inst_csr_wdata` input XLEN: instruction CSR write request
- `csr_mtvec`, `csr_mepc`, `csr_mstatus`, `csr_mie` input XLEN: current CSR values
- `csr_we` output 1, `csr_waddr` output 12, `csr_wdata` output XLEN: arbitrated CSR write port
- `stall` output 1: hold fetch/decode/execute
- `redirect_valid` output 1, `redirect_pc` output XLEN: one-cycle PC redirect
- `halt` output 1: sticky ebreak halt
- `tmr_we` input 1, `tmr_addr` input 4, `tmr_wdata` input XLEN, `tmr_rdata` output XLEN: timer register access
- `timer_irq` output 1: raw pending level, `mtime >= mtimecmp`

## Operation
- FSM states: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, MRET_STATUS, REDIRECT, HALT.
- Events are sampled only in IDLE with `inst_valid=1`. Priority: interrupt > ebreak > ecall > mret.
- Interrupt takes when `timer_irq & csr_mstatus[3] & csr_mie[7]`. The instruction is not executed and its `inst_csr_we` is dropped.
- On event detection in IDLE, the block latches `epc=inst_pc` and `cause`:
  - interrupt: 0x8000_0007
  - ecall: 11
  - ebreak: 3
- It also latches `csr_mtvec & ~3`, `csr_mepc` and `csr_mstatus`. Only direct-mode mtvec is supported.
- Trap entry sequence:
  - IDLE → SAVE_EPC: write mepc (0x341) = epc.
  - SAVE_CAUSE: write mcause (0x342) = cause.
  - SAVE_STATUS: write mstatus (0x300) with MPIE(7)=old MIE, MIE(3)=0, MPP(12:11)=2'b11, other bits unchanged.
  - REDIRECT: `redirect_pc`=latched mtvec.
- mret sequence:
  - IDLE → MRET_STATUS: write mstatus with MIE=old MPIE, MPIE=1, MPP=2'b11.
  - REDIRECT: `redirect_pc`=latched mepc.
- ebreak: IDLE → HALT, with no CSR writes. HALT is terminal until reset; `halt`=1 and `stall`=1.
- Arbitration: in IDLE with no event taken, `csr_we/waddr/wdata` = the `inst_csr_*` inputs. In every other state the instruction port is ignored.
- REDIRECT always returns to IDLE.
- Timer:
  - `mtime` is 64 bits and increments every cycle, wrapping 2^64−1 → 0. It keeps counting in HALT.
  - `tmr_addr` map: 0x0 mtimecmp[31:0], 0x4 mtimecmp[63:32], 0x8 mtime[31:0], 0xC mtime[63:32]. Other addresses read 0 and ignore writes.
  - A write to an mtime half replaces that half and suppresses the increment that cycle.
  - `tmr_rdata` is a combinational read of the current register value.
  - The comparison is 64-bit unsigned.

## Timing
- Reset (asynchronous, any state): state=IDLE, mtime=0, mtimecmp=all ones, latches cleared.
- Outputs in reset: `csr_we`=0, `stall`=0, `redirect_valid`=0, `redirect_pc`=0, `halt`=0, `timer_irq`=0.
- `stall` = (IDLE & event taken) | (state ∉ {IDLE, REDIRECT}). It is combinational in the detection cycle.
- Trap entry latency: detection cycle D → mepc write at D+1, mcause at D+2, mstatus at D+3, `redirect_valid` at D+4. `stall` is high D..D+3.
- mret: mstatus write at D+1, redirect at D+2. `stall` is high D..D+1.
- `redirect_valid` lasts exactly one cycle. In that cycle `csr_we`=0 and `stall`=0.
- An interrupt that becomes pending during a sequence is not taken until IDLE. It is then taken at the first `inst_valid` cycle.
- `timer_irq` is registered-compare-free: it reflects register contents in the same cycle.

## Test plan
- ecall at `inst_pc`=0x8000_0010, mtvec=0x8000_0101, mstatus=0x8 → writes at D+1 0x341←0x8000_0010, D+2 0x342←11, D+3 0x300←0x1880; redirect 0x8000_0100 at D+4.
- mret with mepc=0x8000_0014, mstatus=0x1880 → D+1 0x300←0x1888; redirect 0x8000_0014 at D+2.
- mtimecmp=5, mstatus.MIE=1, mie.MTIE=1, and a CSRRW held valid when mtime reaches 5 → instruction write suppressed; mcause←0x8000_0007; mepc←that PC.
- ebreak → `halt`=1 and `stall`=1 the next cycle, no `csr_we`. `halt` stays set for 100 cycles and clears only on `rst`.
- Idle CSRRW 0x305←0x1234 → `csr_we`=1 the same cycle with identical addr/data. Repeat during SAVE_CAUSE → not forwarded.
- Write mtime hi/lo = 0xFFFF_FFFF/0xFFFF_FFFE → reads …FFFF, then 0 two cycles later. Assert `rst` mid SAVE_CAUSE → IDLE immediately, all outputs 0.
